gates_checker: RTL and testbench
================================

# gates_checker

Self-checking stimulus/response block for the two-input `gates` unit. It sequences `a`/`b` through all four input combinations in the order 00, 01, 10, 11, waits a settle interval on each vector, and samples the seven gate outputs. It compares each sample against the decided truth table and reports a pass flag, a mismatch count, and per-output and per-vector failure masks. It sits beside `gates` on the board-level top: this block drives the inputs and reads back the outputs, so a self-test runs in hardware without the simulation bench.

## Interface
Parameters:
- SETTLE_CYCLES, 2, number of cycles each vector is held before sampling; legal range 1..15

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a run; sampled in IDLE or DONE only
- y  input  7  gate outputs from `gates`: y[0]=y0 … y[6]=y6
- a  output  1  registered stimulus input a
- b  output  1  registered stimulus input b
- busy  output  1  high while a run is in progress (DRIVE or SAMPLE state)
- done  output  1  high in DONE state until the next start or reset
- pass  output  1  valid only when done=1; 1 when err_cnt==0
- err_cnt  output  3  number of vectors with at least one mismatching output (0..4)
- fail_mask  output  7  sticky; bit i set if y[i] mismatched on any vector
- fail_vec  output  4  sticky; bit {a,b} set if that vector had any mismatch

## Operation
- Expected outputs per vector: y0=a&b, y1=~(a&b), y2=a|b, y3=~(a|b), y4=a^b, y5=~(a^b), y6=~a.
- States:
  - IDLE: default after reset.
  - DRIVE: holds the current vector; settle counter runs.
  - SAMPLE: compares `y` with the expected value; updates the sticky results.
  - DONE: run complete.
- IDLE --start--> DRIVE: vector index=0, results cleared, a=0, b=0.
- DRIVE --settle counter reaches SETTLE_CYCLES-1--> SAMPLE.
- SAMPLE --index<3--> DRIVE with index+1; {a,b} is updated on the same edge.
- SAMPLE --index==3--> DONE.
- DONE --start--> DRIVE. This clears err_cnt, fail_mask and fail_vec and sets index=0, exactly as from IDLE.
- `start` is ignored in DRIVE and SAMPLE.
- `{a,b}` always equals the 2-bit vector index while busy. It stays at the last value (11) in DONE and is 00 in IDLE.
- err_cnt increments at most once per vector, saturating at 4, and never wraps.
- pass = done & (err_cnt==0). It is combinational from registers.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_mask=0, fail_vec=0, state=IDLE, index=0, settle counter=0.
- Reset asserted mid-run aborts on that edge. All outputs take their reset values on the following cycle, and partial results are discarded.
- Start accepted at edge k: busy=1 and {a,b}=00 are visible after edge k.
- Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in DRIVE plus 1 in SAMPLE.
- `y` is compared during the SAMPLE cycle, and results are registered at the end of that cycle. `y` is assumed combinational from `a`/`b`; no sampling occurs in DRIVE.
- done rises after edge k + 4·(SETTLE_CYCLES+1). With the default, that is 12 cycles after start, and busy falls on the same edge.
- Results update after each SAMPLE edge, so they are observable incrementally, but they are valid for reporting only when done=1.
- rst and start asserted on the same cycle: reset wins.

## Test plan
- Correct `gates` connected, SETTLE_CYCLES=2, start pulse: {a,b} steps 00→01→10→11, three cycles each; done=1 exactly 12 cycles after start; pass=1, err_cnt=0, fail_mask=7'b0000000, fail_vec=4'b0000.
- Fault injection y4 stuck-at-0: vectors 01 and 10 fail; err_cnt=2, fail_mask=7'b0010000, fail_vec=4'b0110, pass=0.
- Fault injection y6 inverted plus y0 stuck-at-1: all four vectors fail; err_cnt=4 (no wrap), fail_mask=7'b1000001, fail_vec=4'b1111.
- start pulsed again at cycle 5 of a run: ignored; done still arrives at cycle 12 and results are identical to the single-start run.
- rst asserted during the SAMPLE of vector 10 with a y4 fault present: next cycle all outputs are zero and the state is IDLE; a subsequent start produces a full 12-cycle run with fresh results.
- Back-to-back runs from DONE, first with the y4 fault and then with it removed: the second start clears the masks; the second run ends pass=1, err_cnt=0.

Source files
------------

// File: rtl/gates_checker.sv
// gates_checker: steps a/b through 00,01,10,11, waits a settle interval per vector,
// and scores the seven gate outputs against the reference truth table.
module gates_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [6:0] fail_mask,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_r, state_s;
  logic [1:0] idx_r, idx_s;
  logic [3:0] cnt_r, cnt_s;
  logic [2:0] err_cnt_r, err_cnt_s;
  logic [6:0] fail_mask_r, fail_mask_s;
  logic [3:0] fail_vec_r, fail_vec_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic [6:0] mism_s;

  // Reference response of a healthy gates unit for vector {va,vb}.
  function automatic logic [6:0] expected_y(input logic [1:0] v);
    logic va;
    logic vb;
    va = v[1];
    vb = v[0];
    return {~va, ~(va ^ vb), va ^ vb, ~(va | vb), va | vb, ~(va & vb), va & vb};
  endfunction

  // Next-state, sticky-result and output-decode logic.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    err_cnt_s   = err_cnt_r;
    fail_mask_s = fail_mask_r;
    fail_vec_s  = fail_vec_r;
    mism_s      = y ^ expected_y(idx_r);

    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s     = DRIVE;
          idx_s       = 2'd0;
          cnt_s       = 4'd0;
          err_cnt_s   = 3'd0;
          fail_mask_s = 7'd0;
          fail_vec_s  = 4'd0;
        end else begin
          state_s = state_r;
        end
      end
      DRIVE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = SAMPLE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      SAMPLE: begin
        fail_mask_s = fail_mask_r | mism_s;
        if (mism_s != 7'd0) begin
          fail_vec_s = fail_vec_r | (4'd1 << idx_r);
          // One count per failing vector; four vectors means it can never pass 4.
          if (err_cnt_r < 3'd4) begin
            err_cnt_s = err_cnt_r + 3'd1;
          end else begin
            err_cnt_s = err_cnt_r;
          end
        end else begin
          fail_vec_s = fail_vec_r;
        end
        if (idx_r == 2'd3) begin
          state_s = DONE;
        end else begin
          state_s = DRIVE;
          idx_s   = idx_r + 2'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s == DRIVE) || (state_s == SAMPLE);
    done_s = (state_s == DONE);
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= 2'd0;
      cnt_r       <= 4'd0;
      err_cnt_r   <= 3'd0;
      fail_mask_r <= 7'd0;
      fail_vec_r  <= 4'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      err_cnt_r   <= err_cnt_s;
      fail_mask_r <= fail_mask_s;
      fail_vec_r  <= fail_vec_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  // The vector index register drives the stimulus pins directly.
  assign a         = idx_r[1];
  assign b         = idx_r[0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign err_cnt   = err_cnt_r;
  assign fail_mask = fail_mask_r;
  assign fail_vec  = fail_vec_r;
  assign pass      = done_r & (err_cnt_r == 3'd0);

endmodule

// File: tb/tb_gates_checker.sv
// Scoreboard bench for gates_checker: a fault-injectable gates model answers the
// DUT, expected run results are queued at start and checked by a monitor.
module tb_gates_checker;

  localparam int S      = 2;
  localparam int DONE_O = 4 * (S + 1);

  // Truth-table columns per gate, bit v = output for vector {a,b}=v.
  localparam logic [3:0] COL [0:6] = '{4'b1000, 4'b0111, 4'b1110, 4'b0001,
                                       4'b0110, 4'b1001, 4'b0011};

  typedef struct {
    int         start_cyc;
    logic [2:0] err;
    logic [6:0] mask;
    logic [3:0] vec;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] y;
  logic       a, b, busy, done, pass;
  logic [2:0] err_cnt;
  logic [6:0] fail_mask;
  logic [3:0] fail_vec;

  logic [6:0] sa0 = 7'd0, sa1 = 7'd0, inv = 7'd0;
  logic       rst_q = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb_q[$];

  gates_checker #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y), .a(a), .b(b),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_mask(fail_mask), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Gates unit with injectable stuck-at-0, stuck-at-1 and inversion faults.
  always_comb begin
    y = 7'd0;
    for (int i = 0; i < 7; i++)
      y[i] = ((COL[i][{a, b}] & ~sa0[i]) | sa1[i]) ^ inv[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [6:0] f0, input logic [6:0] f1,
                                 input logic [6:0] fi, input int sc);
    exp_t       e;
    int         errs;
    logic [6:0] good, seen, mism;
    errs   = 0;
    e.mask = 7'd0;
    e.vec  = 4'd0;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 7; i++) good[i] = COL[i][v];
      seen = ((good & ~f0) | f1) ^ fi;
      mism = seen ^ good;
      if (mism != 7'd0) begin
        errs++;
        e.vec[v] = 1'b1;
      end
      e.mask |= mism;
    end
    e.err       = 3'(errs);
    e.pass      = (errs == 0);
    e.start_cyc = sc;
    return e;
  endfunction

  // Monitor: checks reset state, the vector walk, and the final report.
  always @(negedge clk) begin : monitor
    int o;
    if (rst_q) begin
      chk("reset_state", 32'({a, b, busy, done, pass, err_cnt, fail_mask, fail_vec}), 32'd0);
    end else if (sb_q.size() > 0) begin
      o = cyc - sb_q[0].start_cyc;
      if (o >= 0 && o < DONE_O) begin
        chk("busy_in_run", 32'(busy), 32'd1);
        chk("done_in_run", 32'(done), 32'd0);
        chk("pass_in_run", 32'(pass), 32'd0);
        chk("ab_vector", 32'({a, b}), 32'(o / (S + 1)));
      end else if (o == DONE_O) begin
        chk("done_latency", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("ab_at_done", 32'({a, b}), 32'd3);
        chk("err_cnt", 32'(err_cnt), 32'(sb_q[0].err));
        chk("fail_mask", 32'(fail_mask), 32'(sb_q[0].mask));
        chk("fail_vec", 32'(fail_vec), 32'(sb_q[0].vec));
        chk("pass", 32'(pass), 32'(sb_q[0].pass));
        void'(sb_q.pop_front());
      end
    end
  end

  // One run: optional ignored start at offset extra_at, optional reset at rst_at.
  task automatic run(input logic [6:0] f0, input logic [6:0] f1, input logic [6:0] fi,
                     input int extra_at, input int rst_at);
    sa0 = f0;
    sa1 = f1;
    inv = fi;
    @(negedge clk);
    start = 1'b1;
    sb_q.push_back(model(f0, f1, fi, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    for (int o = 1; o <= DONE_O; o++) begin
      @(negedge clk);
      start = (o == extra_at);
      if (o == rst_at) begin
        rst = 1'b1;
        sb_q.delete();
        break;
      end
    end
    if (rst) begin
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    logic [6:0] f0, f1, fi;
    int         ex, rs;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run(7'h00, 7'h00, 7'h00, -1, -1);
    run(7'h10, 7'h00, 7'h00, -1, -1);
    run(7'h00, 7'h01, 7'h40, -1, -1);
    run(7'h00, 7'h00, 7'h00, 5, -1);
    run(7'h10, 7'h00, 7'h00, -1, 8);
    run(7'h10, 7'h00, 7'h00, -1, -1);
    run(7'h00, 7'h00, 7'h00, -1, -1);

    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_rst_start", 32'({busy, done}), 32'd0);

    for (int n = 0; n < 24; n++) begin
      f0 = 7'($urandom) & 7'($urandom) & 7'($urandom);
      f1 = 7'($urandom) & 7'($urandom) & 7'($urandom) & ~f0;
      fi = 7'($urandom) & 7'($urandom) & 7'($urandom);
      ex = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : -1;
      rs = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 11)) : -1;
      if (ex == rs) ex = -1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(f0, f1, fi, ex, rs);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
